// File: rtl/sprite_layer.sv
// sprite_layer: positioned, scaled, mirrored, animated sprite layer for the
// VGA pipeline. Looks up one texel per pixel from an external synchronous
// ROM and emits a palette index plus an opaque-hit flag, 3 clocks after the
// DrawX/DrawY that produced them. Position/flip/enable writes are held in
// pending registers and committed only at the latch point in vertical blank.
//
// Ports:
//   vga_clk      pixel clock
//   Reset        asynchronous active-high reset
//   DrawX/DrawY  current pixel column/row
//   blank        1 = active display region
//   pos_wr       strobe capturing pos_x/pos_y/flip_x/enable_in into pending
//   anim_en      allow animation to advance at the latch point
//   rom_address  registered sprite ROM address
//   rom_q        sprite ROM data, valid one clock after rom_address
//   pix_index    registered palette index (0 when no hit)
//   pix_hit      registered opaque-sprite-pixel flag
//   update_ack   one-cycle pulse when a pending update commits
module sprite_layer #(
  parameter int unsigned SPR_W           = 20,
  parameter int unsigned SPR_H           = 14,
  parameter int unsigned SCALE_LOG2      = 1,
  parameter int unsigned FRAMES          = 4,
  parameter int unsigned FRAME_DIV       = 6,
  parameter int unsigned ADDR_W          = 11,
  parameter int unsigned INDEX_W         = 8,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned LATCH_LINE      = 480
) (
  input  logic               vga_clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               pos_wr,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               flip_x,
  input  logic               enable_in,
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INDEX_W-1:0] rom_q,
  output logic [INDEX_W-1:0] pix_index,
  output logic               pix_hit,
  output logic               update_ack
);

  localparam int unsigned BOX_W        = SPR_W << SCALE_LOG2;
  localparam int unsigned BOX_H        = SPR_H << SCALE_LOG2;
  localparam int unsigned FRAME_TEXELS = SPR_W * SPR_H;
  localparam int unsigned FRAME_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned DIV_W        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // Pending (software-visible) and active (display) sprite state
  logic [9:0]         pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic               pend_flip_q, pend_flip_d, pend_en_q, pend_en_d;
  logic               pend_flag_q, pend_flag_d;
  logic [9:0]         act_x_q, act_x_d, act_y_q, act_y_d;
  logic               act_flip_q, act_flip_d, act_en_q, act_en_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               ack_q, ack_d;

  // Pixel pipeline
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic               hit_q, hit_d;
  logic [INDEX_W-1:0] index_q, index_d;

  logic               latch;
  logic [10:0]        dx, dy, lx_raw, lx, ly;
  logic               in_box;
  logic [ADDR_W-1:0]  tex_addr;

  assign rom_address = addr_q;
  assign pix_index   = index_q;
  assign pix_hit     = hit_q;
  assign update_ack  = ack_q;

  // Box test and texel address against the active registers
  always_comb begin
    dx       = {1'b0, DrawX} - {1'b0, act_x_q};
    dy       = {1'b0, DrawY} - {1'b0, act_y_q};
    in_box   = (DrawX >= act_x_q) && (DrawY >= act_y_q) &&
               (dx < 11'(BOX_W)) && (dy < 11'(BOX_H));
    lx_raw   = dx >> SCALE_LOG2;
    lx       = act_flip_q ? (11'(SPR_W - 1) - lx_raw) : lx_raw;
    ly       = dy >> SCALE_LOG2;
    // Only loaded when in_box, so lx/ly are within the sprite and the
    // address stays inside the ROM image
    tex_addr = ADDR_W'(frame_q) * ADDR_W'(FRAME_TEXELS) +
               ADDR_W'(ly) * ADDR_W'(SPR_W) + ADDR_W'(lx);
  end

  // Next-state: pending/active update, animation, pixel pipeline
  always_comb begin
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_flip_d = pend_flip_q;
    pend_en_d   = pend_en_q;
    pend_flag_d = pend_flag_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    act_flip_d  = act_flip_q;
    act_en_d    = act_en_q;
    frame_d     = frame_q;
    div_d       = div_q;

    latch = (DrawY == 10'(LATCH_LINE)) && (DrawX == 10'd0);
    ack_d = latch && pend_flag_q;

    // Commit uses the pending value from before any same-cycle write
    if (latch && pend_flag_q) begin
      act_x_d     = pend_x_q;
      act_y_d     = pend_y_q;
      act_flip_d  = pend_flip_q;
      act_en_d    = pend_en_q;
      pend_flag_d = 1'b0;
    end

    // A write on the latch cycle lands in pending and keeps the flag set
    if (pos_wr) begin
      pend_x_d    = pos_x;
      pend_y_d    = pos_y;
      pend_flip_d = flip_x;
      pend_en_d   = enable_in;
      pend_flag_d = 1'b1;
    end

    if (latch && anim_en) begin
      if (div_q == DIV_W'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    addr_d  = in_box ? tex_addr : addr_q;
    v1_d    = in_box && blank && act_en_q;
    v2_d    = v1_q;
    hit_d   = v2_q && (rom_q != INDEX_W'(TRANSPARENT_IDX));
    index_d = hit_d ? rom_q : '0;
  end

  // State registers
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_flip_q <= 1'b0;
      pend_en_q   <= 1'b0;
      pend_flag_q <= 1'b0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_flip_q  <= 1'b0;
      act_en_q    <= 1'b0;
      frame_q     <= '0;
      div_q       <= '0;
      ack_q       <= 1'b0;
      addr_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      hit_q       <= 1'b0;
      index_q     <= '0;
    end else begin
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_flip_q <= pend_flip_d;
      pend_en_q   <= pend_en_d;
      pend_flag_q <= pend_flag_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_flip_q  <= act_flip_d;
      act_en_q    <= act_en_d;
      frame_q     <= frame_d;
      div_q       <= div_d;
      ack_q       <= ack_d;
      addr_q      <= addr_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      hit_q       <= hit_d;
      index_q     <= index_d;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Testbench for sprite_layer: randomized pixels checked against a
// behavioural model via latency-tagged scoreboard queues.
module tb_sprite_layer;

  localparam int SPR_W = 20, SPR_H = 14, SCALE_LOG2 = 1, FRAMES = 4;
  localparam int FRAME_DIV = 6, ADDR_W = 11, INDEX_W = 8, LATCH_LINE = 480;
  localparam int SCALE = 2 ** SCALE_LOG2;
  localparam int TOTAL = FRAMES * SPR_W * SPR_H;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [9:0]         draw_x = '0, draw_y = '0;
  logic               blank = 1'b0, pos_wr = 1'b0, flip_x = 1'b0, enable_in = 1'b0;
  logic [9:0]         pos_x = '0, pos_y = '0;
  logic               anim_en = 1'b0;
  logic [ADDR_W-1:0]  rom_address;
  logic [INDEX_W-1:0] rom_q = '0;
  logic [INDEX_W-1:0] pix_index;
  logic               pix_hit, update_ack;

  sprite_layer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(SCALE_LOG2), .FRAMES(FRAMES),
    .FRAME_DIV(FRAME_DIV), .ADDR_W(ADDR_W), .INDEX_W(INDEX_W),
    .TRANSPARENT_IDX(0), .LATCH_LINE(LATCH_LINE)
  ) dut (
    .vga_clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
    .pos_wr(pos_wr), .pos_x(pos_x), .pos_y(pos_y), .flip_x(flip_x),
    .enable_in(enable_in), .anim_en(anim_en), .rom_address(rom_address),
    .rom_q(rom_q), .pix_index(pix_index), .pix_hit(pix_hit),
    .update_ack(update_ack)
  );

  always #5 clk = ~clk;

  // External synchronous sprite ROM
  logic [INDEX_W-1:0] rom_mem [0:TOTAL-1];
  always @(posedge clk) begin
    if (int'(rom_address) < TOTAL) rom_q <= rom_mem[rom_address];
    else rom_q <= 8'hFF;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct { int due; int addr; bit ack; } exp1_t;
  typedef struct { int due; bit hit; int idx; } exp3_t;
  exp1_t q1[$];
  exp3_t q3[$];

  // Reference model state
  int m_act_x, m_act_y, m_pend_x, m_pend_y;
  bit m_act_flip, m_act_en, m_pend_flip, m_pend_en, m_flag;
  int m_frame, m_div, m_addr;

  task automatic model_reset();
    m_act_x = 0; m_act_y = 0; m_pend_x = 0; m_pend_y = 0;
    m_act_flip = 0; m_act_en = 0; m_pend_flip = 0; m_pend_en = 0; m_flag = 0;
    m_frame = 0; m_div = 0; m_addr = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one pixel clock of stimulus, push expectations, advance one cycle
  task automatic apply(input int x, input int y, input bit bl, input bit wr,
                       input int px, input int py, input bit fl, input bit en);
    int dx, dy, lx, ly, data;
    bit inbox, vis, hit, ack;
    exp1_t e1;
    exp3_t e3;
    draw_x = 10'(x); draw_y = 10'(y); blank = bl;
    pos_wr = wr; pos_x = 10'(px); pos_y = 10'(py); flip_x = fl; enable_in = en;

    dx = x - m_act_x;
    dy = y - m_act_y;
    inbox = (dx >= 0) && (dy >= 0) && (dx < SPR_W * SCALE) && (dy < SPR_H * SCALE);
    if (inbox) begin
      lx = dx / SCALE;
      if (m_act_flip) lx = SPR_W - 1 - lx;
      ly = dy / SCALE;
      m_addr = m_frame * SPR_W * SPR_H + ly * SPR_W + lx;
    end
    vis  = inbox && bl && m_act_en;
    data = int'(rom_mem[m_addr]);
    hit  = vis && (data != 0);
    ack  = (x == 0) && (y == LATCH_LINE) && m_flag;

    e1.due = cyc + 1; e1.addr = m_addr; e1.ack = ack;
    e3.due = cyc + 3; e3.hit = hit; e3.idx = hit ? data : 0;
    q1.push_back(e1);
    q3.push_back(e3);

    if ((x == 0) && (y == LATCH_LINE)) begin
      if (m_flag) begin
        m_act_x = m_pend_x; m_act_y = m_pend_y;
        m_act_flip = m_pend_flip; m_act_en = m_pend_en;
        m_flag = 0;
      end
      if (anim_en) begin
        m_div++;
        if (m_div == FRAME_DIV) begin
          m_div = 0;
          m_frame = (m_frame + 1) % FRAMES;
        end
      end
    end
    if (wr) begin
      m_pend_x = px; m_pend_y = py; m_pend_flip = fl; m_pend_en = en;
      m_flag = 1;
    end
    @(negedge clk);
  endtask

  task automatic pix(input int x, input int y, input bit bl);
    apply(x, y, bl, 0, 0, 0, 0, 0);
  endtask

  task automatic write_pos(input int px, input int py, input bit fl, input bit en);
    apply($urandom_range(80, 200), $urandom_range(30, 120), 1, 1, px, py, fl, en);
  endtask

  task automatic latch_pt(input bit wr, input int px, input int py, input bit fl, input bit en);
    apply(0, LATCH_LINE, 0, wr, px, py, fl, en);
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0)
        pix($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1) == 1);
      else
        pix($urandom_range(90, 250), $urandom_range(40, 230), $urandom_range(0, 9) != 0);
    end
  endtask

  // Apply one pixel and check the resulting ROM address against a constant
  task automatic probe(input string name, input int x, input int y, input int exp_addr);
    pix(x, y, 1);
    chk(name, int'(rom_address), exp_addr);
  endtask

  // Monitor: compare DUT outputs when their scoreboard entries fall due
  initial begin
    forever begin
      @(negedge clk);
      while (q1.size() > 0 && q1[0].due == cyc) begin
        exp1_t e;
        e = q1.pop_front();
        chk("rom_address", int'(rom_address), e.addr);
        chk("update_ack", int'(update_ack), int'(e.ack));
      end
      while (q3.size() > 0 && q3[0].due == cyc) begin
        exp3_t e;
        e = q3.pop_front();
        chk("pix_hit", int'(pix_hit), int'(e.hit));
        chk("pix_index", int'(pix_index), e.idx);
      end
    end
  end

  initial begin
    for (int i = 0; i < TOTAL; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    rom_mem[21] = 8'h3C;
    rom_mem[22] = 8'h00;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset rom_address", int'(rom_address), 0);
    chk("reset pix_hit", int'(pix_hit), 0);
    chk("reset pix_index", int'(pix_index), 0);
    chk("reset update_ack", int'(update_ack), 0);
    rst = 1'b0;

    // Disabled sprite: no hits anywhere
    rand_pix(40);

    // Place sprite at (100,50), commit at the latch point
    write_pos(100, 50, 0, 1);
    rand_pix(20);
    latch_pt(0, 0, 0, 0, 0);
    pix(5, LATCH_LINE, 0);

    // Texel mapping and opaque/transparent texels
    probe("addr_102_52", 102, 52, 21);
    pix(104, 52, 1);
    pix(100, 50, 1);
    pix(139, 77, 1);
    pix(140, 77, 1);
    pix(139, 78, 1);
    pix(99, 50, 1);
    rand_pix(300);

    // Mirrored
    write_pos(100, 50, 1, 1);
    latch_pt(0, 0, 0, 0, 0);
    probe("addr_flip_102_52", 102, 52, 38);
    rand_pix(100);

    // Mid-frame write stays pending until the next latch
    write_pos(200, 200, 0, 1);
    rand_pix(150);
    latch_pt(0, 0, 0, 0, 0);
    rand_pix(150);

    // Write on the latch cycle with nothing pending: no commit yet
    latch_pt(1, 100, 50, 0, 1);
    rand_pix(100);
    latch_pt(0, 0, 0, 0, 0);
    rand_pix(80);

    // Write on the latch cycle with an older write pending: old one commits
    write_pos(300, 100, 0, 1);
    latch_pt(1, 100, 50, 0, 1);
    rand_pix(60);
    latch_pt(0, 0, 0, 0, 0);
    rand_pix(60);

    // Animation: 24 latches cycle frames 0,1,2,3,0
    anim_en = 1'b1;
    for (int l = 1; l <= 24; l++) begin
      latch_pt(0, 0, 0, 0, 0);
      pix(100, 50, 1);
      rand_pix(15);
      if (l == 6) probe("anim_frame1_texel0", 100, 50, 280);
      if (l == 12) probe("anim_frame2_texel0", 100, 50, 560);
    end
    probe("anim_wrap_texel0", 100, 50, 0);
    anim_en = 1'b0;

    // Reset mid-line while an opaque pixel is showing
    pix(102, 52, 1);
    pix(103, 52, 1);
    pix(102, 53, 1);
    chk("pre_reset pix_hit", int'(pix_hit), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset pix_hit", int'(pix_hit), 0);
    chk("async_reset rom_address", int'(rom_address), 0);
    chk("async_reset update_ack", int'(update_ack), 0);
    q1.delete();
    q3.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Invisible until a new write and latch
    for (int i = 0; i < 40; i++) pix($urandom_range(0, 60), $urandom_range(0, 40), 1);
    rand_pix(40);
    latch_pt(0, 0, 0, 0, 0);
    rand_pix(30);
    write_pos(100, 50, 0, 1);
    latch_pt(0, 0, 0, 0, 0);
    rand_pix(200);

    // Drain outstanding expectations
    repeat (4) @(negedge clk);
    chk("scoreboard drained", q1.size() + q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
